// File: rtl/axi4lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axi4lite_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_ADDR_W = 32;
    localparam int REG_DATA_W = 32;
    localparam int REG_STRB_W = REG_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
        logic [REG_STRB_W-1:0] wstrb;
    } reg_req_t;

endpackage

// File: rtl/axi4lite_skid_slot.sv
// Single-entry valid/ready holding register for one AXI channel.
// Latency: 1 cycle from input handshake to out_vld.
// Backpressure: in_rdy = !full; the slot frees only when the consumer pops it.
module axi4lite_skid_slot #(
    parameter int W = 32
) (
    input  logic         core_clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    logic         full_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else if (in_vld && !full_q) begin
            full_q <= 1'b1;
            dat_q  <= in_dat;
        end else if (out_rdy) begin
            full_q <= 1'b0;
        end
    end

    assign in_rdy  = !full_q;
    assign out_vld = full_q;
    assign out_dat = dat_q;

endmodule

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave converting one write or read at a time into a single register-bus request.
// Latency: 2 cycles handshake-to-reg_req, response 1 cycle after reg_ack (or after timeout).
// Backpressure: each of AW/W/AR holds one entry; xREADY drops while that entry is full.
module axi4lite_reg_bridge
    import axi4lite_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = REG_DATA_W,
    parameter int ADDR_WIDTH     = REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(TIMEOUT_CYCLES);

    logic                             aw_vld, w_vld, ar_vld;
    logic                             aw_pop, w_pop, ar_pop;
    logic [ADDR_WIDTH-1:0]            aw_dat, ar_dat;
    logic [DATA_WIDTH+STRB_WIDTH-1:0] w_dat;

    axi4lite_skid_slot #(.W(ADDR_WIDTH)) u_aw_slot (
        .core_clk (ACLK),    .rst     (ARESET),
        .in_vld   (AWVALID), .in_rdy  (AWREADY), .in_dat (AWADDR),
        .out_vld  (aw_vld),  .out_dat (aw_dat),  .out_rdy (aw_pop)
    );

    axi4lite_skid_slot #(.W(DATA_WIDTH + STRB_WIDTH)) u_w_slot (
        .core_clk (ACLK),    .rst     (ARESET),
        .in_vld   (WVALID),  .in_rdy  (WREADY),  .in_dat ({WDATA, WSTRB}),
        .out_vld  (w_vld),   .out_dat (w_dat),   .out_rdy (w_pop)
    );

    axi4lite_skid_slot #(.W(ADDR_WIDTH)) u_ar_slot (
        .core_clk (ACLK),    .rst     (ARESET),
        .in_vld   (ARVALID), .in_rdy  (ARREADY), .in_dat (ARADDR),
        .out_vld  (ar_vld),  .out_dat (ar_dat),  .out_rdy (ar_pop)
    );

    state_e                state_q, state_d;
    reg_req_t              req_q, req_d;
    logic                  req_vld_q, req_vld_d;
    logic                  prefer_rd_q, prefer_rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic wr_elig, rd_elig, issue_wr, issue_rd, timed_out, err;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_vld_q   <= 1'b0;
            prefer_rd_q <= 1'b0;
            cnt_q       <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_vld_q   <= req_vld_d;
            prefer_rd_q <= prefer_rd_d;
            cnt_q       <= cnt_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
        end
    end

    // prefer_rd_q is set after a write is served, so a simultaneous read wins next.
    assign wr_elig   = aw_vld && w_vld;
    assign rd_elig   = ar_vld;
    assign issue_wr  = wr_elig && (!rd_elig || !prefer_rd_q);
    assign issue_rd  = rd_elig && !issue_wr;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err       = !reg_ack || reg_err;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        req_vld_d   = req_vld_q;
        prefer_rd_d = prefer_rd_q;
        cnt_d       = cnt_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        aw_pop      = 1'b0;
        w_pop       = 1'b0;
        ar_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (issue_wr) begin
                    req_d.we    = 1'b1;
                    req_d.addr  = REG_ADDR_W'(aw_dat);
                    req_d.wdata = REG_DATA_W'(w_dat[DATA_WIDTH+STRB_WIDTH-1:STRB_WIDTH]);
                    req_d.wstrb = REG_STRB_W'(w_dat[STRB_WIDTH-1:0]);
                    aw_pop      = 1'b1;
                    w_pop       = 1'b1;
                    prefer_rd_d = 1'b1;
                    req_vld_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = REQ;
                end else if (issue_rd) begin
                    req_d.we    = 1'b0;
                    req_d.addr  = REG_ADDR_W'(ar_dat);
                    req_d.wdata = '0;
                    req_d.wstrb = '0;
                    ar_pop      = 1'b1;
                    prefer_rd_d = 1'b0;
                    req_vld_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // An ack landing on the final timeout cycle is still honoured.
                if (reg_ack || timed_out) begin
                    req_vld_d = 1'b0;
                    state_d   = RESP;
                    if (req_q.we) begin
                        bvalid_d = 1'b1;
                        bresp_d  = err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = err ? RESP_SLVERR : RESP_OKAY;
                        rdata_d  = reg_ack ? reg_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if ((bvalid_q && BREADY) || (rvalid_q && RREADY)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg_req   = req_vld_q;
    assign reg_we    = req_q.we;
    assign reg_addr  = ADDR_WIDTH'(req_q.addr);
    assign reg_wdata = DATA_WIDTH'(req_q.wdata);
    assign reg_wstrb = STRB_WIDTH'(req_q.wstrb);
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign RVALID    = rvalid_q;
    assign RRESP     = rresp_q;
    assign RDATA     = rdata_q;

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed scoreboard bench for axi4lite_reg_bridge.
// Inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_reg_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          ACLK, ARESET;
    logic [AW-1:0] AWADDR;  logic AWVALID, AWREADY;
    logic [DW-1:0] WDATA;   logic [SW-1:0] WSTRB; logic WVALID, WREADY;
    logic [1:0]    BRESP;   logic BVALID, BREADY;
    logic [AW-1:0] ARADDR;  logic ARVALID, ARREADY;
    logic [DW-1:0] RDATA;   logic [1:0] RRESP; logic RVALID, RREADY;
    logic          reg_req, reg_we, reg_ack, reg_err;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata, reg_rdata;
    logic [SW-1:0] reg_wstrb;

    axi4lite_reg_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } req_exp_t;

    typedef struct {
        logic          is_wr;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        req_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.strb = strb;
        req_q.push_back(e);
    endtask

    task automatic push_rsp(input logic is_wr, input logic [1:0] resp, input logic [DW-1:0] data);
        rsp_exp_t e;
        e.is_wr = is_wr; e.resp = resp; e.data = data;
        rsp_q.push_back(e);
    endtask

    // Presents the selected channels for exactly one cycle; each must be ready.
    task automatic send(input logic do_aw, input logic do_w, input logic do_ar,
                        input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] strb, input logic [AW-1:0] raddr);
        if (do_aw) begin check("awready", AWREADY, 1); AWVALID = 1'b1; AWADDR = waddr; end
        if (do_w)  begin check("wready",  WREADY,  1); WVALID  = 1'b1; WDATA = wdata; WSTRB = strb; end
        if (do_ar) begin check("arready", ARREADY, 1); ARVALID = 1'b1; ARADDR = raddr; end
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    endtask

    // mode 0: never ack (timeout), 1: ack after delay, 2: only check the request.
    task automatic serve(input int mode, input int delay,
                         input logic [DW-1:0] rdata, input logic err);
        int n = 0;
        int sz;
        req_exp_t e;
        while (!reg_req && n < 50) begin @(negedge ACLK); n++; end
        check("req_seen", reg_req, 1);
        if (!reg_req) return;
        sz = req_q.size();
        check("req_pending", (sz != 0), 1);
        if (sz == 0) return;
        e = req_q.pop_front();
        check("reg_we", reg_we, e.we);
        check("reg_addr", reg_addr, e.addr);
        if (e.we) begin
            check("reg_wdata", reg_wdata, e.wdata);
            check("reg_wstrb", reg_wstrb, e.strb);
        end
        if (mode == 1) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge ACLK);
                check("req_held", reg_req, 1);
            end
            reg_ack = 1'b1; reg_rdata = rdata; reg_err = err;
            @(negedge ACLK);
            reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = $urandom;
            check("req_drop", reg_req, 0);
        end else if (mode == 0) begin
            n = 0;
            while (reg_req && n < 40) begin @(negedge ACLK); n++; end
            check("timeout_len", n, TO);
        end
    endtask

    task automatic wait_rsp(input int hold);
        int n = 0;
        int sz;
        rsp_exp_t e;
        while (!BVALID && !RVALID && n < 50) begin @(negedge ACLK); n++; end
        check("rsp_seen", (BVALID || RVALID), 1);
        if (!BVALID && !RVALID) return;
        sz = rsp_q.size();
        check("rsp_pending", (sz != 0), 1);
        if (sz == 0) return;
        e = rsp_q.pop_front();
        check("bvalid", BVALID, e.is_wr);
        check("rvalid", RVALID, !e.is_wr);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                @(negedge ACLK);
                check("valid_held", e.is_wr ? BVALID : RVALID, 1);
            end
            if (e.is_wr) check("bresp", BRESP, e.resp);
            else begin
                check("rresp", RRESP, e.resp);
                check("rdata", RDATA, e.data);
            end
        end
        if (e.is_wr) BREADY = 1'b1; else RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        check("valid_clear", (BVALID || RVALID), 0);
    endtask

    initial begin
        logic seen;
        ARESET = 1'b1;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
        AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
        reg_ack = 0; reg_err = 0; reg_rdata = '0;
        repeat (3) @(negedge ACLK);
        check("rst_req", reg_req, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rst_awready", AWREADY, 1);
        check("rst_wready", WREADY, 1);
        check("rst_arready", ARREADY, 1);
        check("rst_we", reg_we, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_wstrb", reg_wstrb, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_rdata", RDATA, 0);

        // Basic write, AW and W together, B held 5 cycles
        push_req(1, 32'h10, 32'hDEADBEEF, 4'hF);
        push_rsp(1, 2'b00, '0);
        send(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, '0);
        check("aw_full", AWREADY, 0);
        serve(1, 1, '0, 0);
        wait_rsp(5);

        // Basic read, ack after 3 cycles
        push_req(0, 32'h20, '0, '0);
        push_rsp(0, 2'b00, 32'h12345678);
        send(0, 0, 1, '0, '0, '0, 32'h20);
        serve(1, 3, 32'h12345678, 0);
        wait_rsp(3);

        // Round-robin: last served was a read, so write then read, twice
        for (int r = 0; r < 2; r++) begin
            logic [DW-1:0] wd, rd;
            logic [SW-1:0] st;
            wd = $urandom; rd = $urandom;
            st = (r == 0) ? 4'h3 : 4'h0;
            push_req(1, 32'h30 + 32'(r * 8), wd, st);
            push_req(0, 32'h34 + 32'(r * 8), '0, '0);
            push_rsp(1, 2'b00, '0);
            push_rsp(0, 2'b00, rd);
            send(1, 1, 1, 32'h30 + 32'(r * 8), wd, st, 32'h34 + 32'(r * 8));
            serve(1, 0, '0, 0);
            wait_rsp(0);
            serve(1, 0, rd, 0);
            wait_rsp(0);
        end

        // W four cycles ahead of AW
        push_req(1, 32'h40, 32'h11223344, 4'hC);
        push_rsp(1, 2'b00, '0);
        send(0, 1, 0, '0, 32'h11223344, 4'hC, '0);
        check("w_full", WREADY, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            seen = seen | reg_req;
        end
        check("no_req_without_aw", seen, 0);
        send(1, 0, 0, 32'h40, '0, '0, '0);
        serve(1, 0, '0, 0);
        wait_rsp(0);

        // Read timeout gives SLVERR with zero data
        push_req(0, 32'h50, '0, '0);
        push_rsp(0, 2'b10, '0);
        send(0, 0, 1, '0, '0, '0, 32'h50);
        serve(0, 0, '0, 0);
        wait_rsp(0);

        // Decode error on a write
        push_req(1, 32'h60, 32'hA5A5A5A5, 4'hF);
        push_rsp(1, 2'b10, '0);
        send(1, 1, 0, 32'h60, 32'hA5A5A5A5, 4'hF, '0);
        serve(1, 2, '0, 1);
        wait_rsp(0);

        // Reset in the middle of a write request; it must vanish
        push_req(1, 32'h70, 32'h0BADF00D, 4'hF);
        send(1, 1, 0, 32'h70, 32'h0BADF00D, 4'hF, '0);
        serve(2, 0, '0, 0);
        @(negedge ACLK);
        check("mid_req_high", reg_req, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid_rst_req", reg_req, 0);
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_rvalid", RVALID, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("mid_rst_awready", AWREADY, 1);
        check("mid_rst_wready", WREADY, 1);
        check("mid_rst_arready", ARREADY, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            seen = seen | BVALID | RVALID | reg_req;
        end
        check("dropped_no_rsp", seen, 0);

        // After reset the write wins a tie even though a write was served last
        push_req(1, 32'h80, 32'hFEEDFACE, 4'h5);
        push_req(0, 32'h84, '0, '0);
        push_rsp(1, 2'b00, '0);
        push_rsp(0, 2'b00, 32'h87654321);
        send(1, 1, 1, 32'h80, 32'hFEEDFACE, 4'h5, 32'h84);
        serve(1, 0, '0, 0);
        wait_rsp(0);
        serve(1, 1, 32'h87654321, 0);
        wait_rsp(0);

        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_bridge.md
Name: axi4lite_reg_bridge

Overview:
AXI4-Lite slave that accepts one write (AW+W) or one read (AR) at a time and converts it into a single-beat request on the simple register bus consumed by the config register file. It sits directly downstream of the system's AXI4-Lite master port and upstream of the register decode/storage block. It also returns BRESP/RRESP, including a timeout error when the register side never acknowledges.

Parameters:
DATA_WIDTH, 32, data bus width in bits; WSTRB width is DATA_WIDTH/8.
ADDR_WIDTH, 32, byte address width; passed unchanged to reg_addr.
TIMEOUT_CYCLES, 16, maximum cycles reg_req may wait for reg_ack before SLVERR; must be at least 2.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  synchronous reset, active-high.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address buffer empty.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte strobes.
WVALID  in  1  write data valid.
WREADY  out  1  write data buffer empty.
BRESP  out  2  write response: 00 = OKAY, 10 = SLVERR.
BVALID  out  1  write response valid.
BREADY  in  1  write response accepted.
ARADDR  in  ADDR_WIDTH  read address.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address buffer empty.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response: 00 = OKAY, 10 = SLVERR.
RVALID  out  1  read data valid.
RREADY  in  1  read data accepted.
reg_req  out  1  register access request; held high until reg_ack or timeout.
reg_we  out  1  1 = write, 0 = read; stable while reg_req is high.
reg_addr  out  ADDR_WIDTH  register byte address.
reg_wdata  out  DATA_WIDTH  write data.
reg_wstrb  out  DATA_WIDTH/8  write strobes, passed through unchanged (all-zero strobes are still issued).
reg_ack  in  1  access complete; valid only while reg_req is high.
reg_rdata  in  DATA_WIDTH  read data; sampled in the reg_ack cycle.
reg_err  in  1  decode error; sampled in the reg_ack cycle, gives SLVERR.

Behaviour:
- Reset (ARESET=1 at a clock edge): every buffer is emptied, FSM returns to IDLE, timeout counter clears, round-robin flag selects write. BVALID, RVALID, reg_req, reg_we = 0. BRESP, RRESP, RDATA, reg_addr, reg_wdata, reg_wstrb = 0. AWREADY, WREADY, ARREADY = 1 starting the first cycle after reset releases. A transaction in flight when reset hits is dropped with no response.
- AW, W and AR each have an independent single-entry holding register. xREADY = !full. A buffer fills on xVALID&&xREADY and empties when its request is issued. AW and W may arrive in any order or in the same cycle. ARCACHE/ARPROT/AWCACHE/AWPROT are not ports and are ignored.
- FSM states: IDLE -> REQ -> RESP -> IDLE.
- In IDLE, a write is eligible when AW and W are both full; a read is eligible when AR is full. If only one is eligible, it is issued. If both are eligible, priority alternates: the type not served last wins, and write wins first after reset. Issuing loads reg_*, sets reg_req=1 on the next cycle and moves to REQ. Minimum latency from the handshake to reg_req is 2 cycles (buffer, then IDLE issue).
- In REQ, reg_req stays high. The cycle after reg_ack=1 samples the response and sets reg_req=0. Write: BVALID=1, BRESP = reg_err ? 10 : 00. Read: RVALID=1, RDATA = reg_rdata, RRESP likewise. The FSM moves to RESP.
- Timeout: the counter runs while in REQ. If TIMEOUT_CYCLES cycles pass with no reg_ack, reg_req drops and the response is SLVERR (RDATA=0) through the same path. If reg_ack arrives in the timeout cycle, the ack wins.
- In RESP, BVALID/RVALID and the response data stay stable until BREADY/RREADY. On the handshake, the valid clears and the FSM returns to IDLE. Back-to-back transactions need at least one IDLE cycle between them.
- Buffers keep accepting new AW/W/AR during REQ/RESP while empty, so one transaction of each type can be queued behind the active one.

Decomposition:
- Package axi4lite_reg_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the FSM state enum (IDLE, REQ, RESP) and the reg-bus request struct (we, addr, wdata, wstrb).
- One sub-module, axi4lite_skid_slot: a parameterised single-entry valid/ready holding register, instantiated three times for AW, W and AR.

Test Plan:
- Write: AW=0x10 and W=0xDEADBEEF/strb 0xF in the same cycle, reg_ack one cycle after reg_req -> reg_we=1, reg_addr=0x10, reg_wdata=0xDEADBEEF; BVALID with BRESP=00; BVALID held while BREADY is low for 5 cycles.
- Read: AR=0x20, reg_rdata=0x12345678, reg_ack after 3 cycles -> RDATA=0x12345678, RRESP=00; RVALID stays until RREADY.
- W arrives 4 cycles before AW -> WREADY=0 after the W handshake, no reg_req until AW arrives, then a single write with the correct address and data.
- AW+W and AR all full in the same IDLE cycle, repeated twice -> issue order is write, read, write, read.
- No reg_ack (TIMEOUT_CYCLES=16) -> reg_req drops after 16 cycles, RRESP=10, RDATA=0. reg_err=1 on a write -> BRESP=10.
- ARESET asserted mid-REQ -> the next cycle has reg_req=0, BVALID=0, RVALID=0 and all READYs=1 after release; the dropped transaction gets no response.
